// File: rtl/i2c_controller.sv
// i2c_controller: single-byte I2C initiator (START, addr+R/W, one data byte,
// STOP) with open-drain SCL/SDA enables and a ready/start/done handshake.
// Optional build macro CLOCK_STRETCH_EN: honour target clock stretching in q2.
module i2c_controller #(
    parameter int CLK_DIV = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_AACK  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_DACK  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    logic [2:0]    state, nxt_state;
    logic [1:0]    q, nxt_q;
    logic [2:0]    bitn, nxt_bitn;
    logic [7:0]    sh, nxt_sh;
    logic [CW-1:0] qcnt;
    logic [7:0]    rx;
    logic [7:0]    wdata_l;
    logic          rw_l;
    logic          hold, qend, accept, sample;
    logic          nxt_scl, nxt_sda;

`ifdef CLOCK_STRETCH_EN
    // Target holds SCL low after we release it: freeze the quarter counter.
    assign hold = (state != S_IDLE) && (q == 2'd2) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    assign accept = start && ready;
    assign qend   = (state != S_IDLE) && !hold && (qcnt == QMAX);
    assign sample = qend && (q == 2'd2);

    // Next state / quarter / bit, and the bus levels for the coming quarter.
    always_comb begin
        nxt_state = state;
        nxt_q     = q;
        nxt_bitn  = bitn;
        nxt_sh    = sh;
        if (accept) begin
            nxt_state = S_START;
            nxt_q     = 2'd0;
            nxt_sh    = {addr, rw};
        end else if (qend) begin
            if (q != 2'd3) begin
                nxt_q = q + 2'd1;
            end else begin
                nxt_q = 2'd0;
                case (state)
                    S_START: begin
                        nxt_state = S_ADDR;
                        nxt_bitn  = 3'd0;
                    end
                    S_ADDR: begin
                        if (bitn == 3'd7) nxt_state = S_AACK;
                        nxt_bitn = bitn + 3'd1;
                        nxt_sh   = {sh[6:0], 1'b0};
                    end
                    S_AACK: begin
                        nxt_state = nack ? S_STOP : S_DATA;
                        nxt_bitn  = 3'd0;
                        nxt_sh    = wdata_l;
                    end
                    S_DATA: begin
                        if (bitn == 3'd7) nxt_state = S_DACK;
                        nxt_bitn = bitn + 3'd1;
                        nxt_sh   = {sh[6:0], 1'b0};
                    end
                    S_DACK:  nxt_state = S_STOP;
                    S_STOP:  nxt_state = S_IDLE;
                    default: nxt_state = S_IDLE;
                endcase
            end
        end

        nxt_scl = 1'b0;
        nxt_sda = 1'b0;
        case (nxt_state)
            S_START: nxt_sda = nxt_q[1];
            S_ADDR: begin
                nxt_scl = !nxt_q[1];
                nxt_sda = !nxt_sh[7];
            end
            S_AACK, S_DACK: nxt_scl = !nxt_q[1];
            S_DATA: begin
                nxt_scl = !nxt_q[1];
                nxt_sda = !rw_l && !nxt_sh[7];
            end
            S_STOP: begin
                nxt_scl = (nxt_q == 2'd0);
                nxt_sda = !nxt_q[1];
            end
            default: ;
        endcase
    end

    // Registered state, bus enables, sampling and handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            q       <= 2'd0;
            bitn    <= 3'd0;
            sh      <= 8'd0;
            qcnt    <= '0;
            rx      <= 8'd0;
            wdata_l <= 8'd0;
            rw_l    <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            rdata   <= 8'd0;
            nack    <= 1'b0;
        end else begin
            state  <= nxt_state;
            q      <= nxt_q;
            bitn   <= nxt_bitn;
            sh     <= nxt_sh;
            scl_oe <= nxt_scl;
            sda_oe <= nxt_sda;
            done   <= 1'b0;
            if (accept) begin
                rw_l    <= rw;
                wdata_l <= wdata;
                nack    <= 1'b0;
                ready   <= 1'b0;
                qcnt    <= '0;
            end else if (state != S_IDLE && !hold) begin
                qcnt <= (qcnt == QMAX) ? '0 : qcnt + 1'b1;
            end
            if (sample) begin
                case (state)
                    S_AACK: if (sda_i) nack <= 1'b1;
                    S_DACK: if (!rw_l && sda_i) nack <= 1'b1;
                    S_DATA: if (rw_l) begin
                        rx <= {rx[6:0], sda_i};
                        if (bitn == 3'd7) rdata <= {rx[6:0], sda_i};
                    end
                    default: ;
                endcase
            end
            if (qend && q == 2'd3 && state == S_STOP) begin
                done  <= 1'b1;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with a behavioural I2C target at 0x42
// that ACKs, returns 0x21 on reads, and can stretch SCL in data bit 3.
module tb_i2c_controller;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       ready, done, nack, scl_oe, sda_oe;
    logic [7:0] rdata;

    logic scl, sda, stretch_on;
    logic tgt_pull = 1'b0;
    logic stretch_mode = 1'b0;
    logic in_slot13 = 1'b0;
    int   st_cnt = 0;

    int checks = 0;
    int errors = 0;

    // target model state
    int         k = 0;
    int         s;
    int         npos = 0;
    logic       scl_q = 1'b1, sda_q = 1'b1;
    logic [7:0] sh = 8'd0, dsh = 8'd0, abyte = 8'd0;
    logic [7:0] last_a = 8'd0, last_d = 8'd0;
    logic       acked = 1'b0, dack_lvl = 1'b0;
    logic [7:0] rd_byte = 8'h21;

    i2c_controller #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst_n), .start(start), .addr(addr), .rw(rw),
        .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .nack(nack),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl), .sda_i(sda)
    );

    always #5 clk = ~clk;

    assign stretch_on = stretch_mode && in_slot13 && !scl_oe && (st_cnt < 50);
    assign scl = !scl_oe && !stretch_on;
    assign sda = !sda_oe && !tgt_pull;

    always @(posedge clk) if (stretch_on) st_cnt <= st_cnt + 1;

    // Target: START detect, sample on SCL rise, drive SDA on SCL fall.
    always @(scl, sda) begin
        if (scl_q === 1'b1 && scl === 1'b1 && sda_q === 1'b1 && sda === 1'b0) begin
            k = 0;
            acked = 1'b0;
            tgt_pull = 1'b0;
        end else if (scl_q === 1'b0 && scl === 1'b1) begin
            k++;
            npos++;
            if (k <= 8) sh = {sh[6:0], sda};
            if (k == 8) begin
                abyte = sh;
                last_a = sh;
            end
            if (k >= 10 && k <= 17) dsh = {dsh[6:0], sda};
            if (k == 17) last_d = dsh;
            if (k == 18) dack_lvl = sda;
        end else if (scl_q === 1'b1 && scl === 1'b0) begin
            s = k + 1;
            in_slot13 = (s == 13);
            if (s == 9) begin
                acked = (abyte[7:1] == 7'h42);
                tgt_pull = acked;
            end else if (s >= 10 && s <= 17 && acked && abyte[0]) begin
                tgt_pull = !rd_byte[17 - s];
            end else if (s == 18 && acked && !abyte[0]) begin
                tgt_pull = 1'b1;
            end else begin
                tgt_pull = 1'b0;
            end
        end
        scl_q = scl;
        sda_q = sda;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] w);
        check("ready_before_accept", 32'(ready), 32'd1);
        addr = a;
        rw = r;
        wdata = w;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ready_after_accept", 32'(ready), 32'd0);
    endtask

    task automatic wait_done(input int pre, input int exp, input string tag);
        int n;
        n = pre;
        while (done !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, exp);
    endtask

    initial begin
        int base;
        int exp_st;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // write 0xA5 to 0x42
        base = npos;
        launch(7'h42, 1'b0, 8'hA5);
        wait_done(0, 320, "wr_latency");
        check("wr_addr_byte", 32'(last_a), 32'h84);
        check("wr_data_byte", 32'(last_d), 32'hA5);
        check("wr_nack", 32'(nack), 32'd0);
        check("wr_scl_pulses", npos - base, 19);
        repeat (4) @(negedge clk);

        // no responder at 0x10
        base = npos;
        launch(7'h10, 1'b0, 8'h3C);
        wait_done(0, 176, "nack_latency");
        check("nack_flag", 32'(nack), 32'd1);
        check("nack_scl_pulses", npos - base, 10);
        check("nack_bus_scl", 32'(scl_oe), 32'd0);
        check("nack_bus_sda", 32'(sda_oe), 32'd0);
        repeat (4) @(negedge clk);

        // start pulse during DATA is ignored
        last_a = 8'd0;
        last_d = 8'd0;
        launch(7'h42, 1'b0, 8'hA5);
        repeat (200) @(posedge clk);
        #1 addr = 7'h11;
        rw = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_ready", 32'(ready), 32'd0);
        wait_done(201, 320, "ign_latency");
        check("ign_addr_byte", 32'(last_a), 32'h84);
        check("ign_data_byte", 32'(last_d), 32'hA5);

        // start coincident with done: read from 0x42
        last_a = 8'd0;
        dack_lvl = 1'b0;
        launch(7'h42, 1'b1, 8'h00);
        wait_done(0, 320, "rd_latency");
        check("rd_addr_byte", 32'(last_a), 32'h85);
        check("rd_rdata", 32'(rdata), 32'h21);
        check("rd_nack", 32'(nack), 32'd0);
        check("rd_dack_released", 32'(dack_lvl), 32'd1);
        repeat (4) @(negedge clk);

        // clock stretching in data bit 3
`ifdef CLOCK_STRETCH_EN
        stretch_mode = 1'b1;
        exp_st = 370;
`else
        exp_st = 320;
`endif
        last_d = 8'd0;
        launch(7'h42, 1'b0, 8'hA5);
        wait_done(0, exp_st, "stretch_latency");
        check("stretch_data_byte", 32'(last_d), 32'hA5);
        stretch_mode = 1'b0;
        repeat (4) @(negedge clk);

        // reset in the middle of ADDR (bit 1, q1)
        launch(7'h42, 1'b0, 8'hA5);
        repeat (37) @(posedge clk);
        #3;
        check("pre_rst_scl_oe", 32'(scl_oe), 32'd1);
        check("pre_rst_sda_oe", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
        check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_scl_idle", 32'(scl_oe), 32'd0);
        last_a = 8'd0;
        last_d = 8'd0;
        launch(7'h42, 1'b0, 8'hA5);
        wait_done(0, 320, "post_rst_latency");
        check("post_rst_addr_byte", 32'(last_a), 32'h84);
        check("post_rst_data_byte", 32'(last_d), 32'hA5);
        check("post_rst_nack", 32'(nack), 32'd0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
